// File: rtl/roe_rf_pkg.sv
// Shared types and widths for the register-file port arbiter.
package roe_rf_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int PA_W       = 2;
  localparam int LOWER_W    = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} rf_state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} rf_owner_t;
endpackage

// File: rtl/rf_port_arbiter_pa_tracker.sv
// Per-requester play-area register; eff_pa forwards a newly selected bank
// so the access being captured already uses it.
module pa_tracker
  import roe_rf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      i_set_pa,
  input  logic            i_capture,
  output logic [PA_W-1:0] o_pa,
  output logic [PA_W-1:0] o_eff_pa
);
  logic [PA_W-1:0] r_pa;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pa <= '0;
    end else if (i_capture && i_set_pa[2]) begin
      r_pa <= i_set_pa[1:0];
    end
  end

  assign o_pa     = r_pa;
  assign o_eff_pa = i_set_pa[2] ? i_set_pa[1:0] : r_pa;
endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin sharing of a single-ported register file between cpu and dbg.
// Handshake: req is held until gnt (ACCESS cycle); done pulses one cycle later.
module rf_port_arbiter
  import roe_rf_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [2:0]            cpu_set_pa,
  input  logic [LOWER_W-1:0]    cpu_lower,
  input  logic                  cpu_we,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_done,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic [PA_W-1:0]       cpu_pa,
  input  logic                  dbg_req,
  input  logic [2:0]            dbg_set_pa,
  input  logic [LOWER_W-1:0]    dbg_lower,
  input  logic                  dbg_we,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_done,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic [PA_W-1:0]       dbg_pa,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic                  rf_we,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [DATA_W-1:0]     rf_rdata,
  output logic [1:0]            o_fsm_state
);
  rf_state_t             r_state;
  rf_owner_t             r_owner;
  rf_owner_t             r_last_owner;
  logic [REG_ADDR_W-1:0] r_addr;
  logic                  r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_cpu_rdata;
  logic [DATA_W-1:0]     r_dbg_rdata;

  logic                  w_sample;
  rf_owner_t             w_last_eff;
  rf_owner_t             w_win;
  logic                  w_cpu_cap;
  logic                  w_dbg_cap;
  logic [PA_W-1:0]       w_cpu_eff_pa;
  logic [PA_W-1:0]       w_dbg_eff_pa;
  logic [REG_ADDR_W-1:0] w_cap_addr;
  logic                  w_cap_we;
  logic [DATA_W-1:0]     w_cap_wdata;

  assign w_sample = ((r_state == IDLE) || (r_state == RESP)) && (cpu_req || dbg_req);

  // In RESP the finishing owner counts as last_owner already, so back-to-back ties alternate.
  assign w_last_eff = (r_state == RESP) ? r_owner : r_last_owner;

  always_comb begin
    w_win = OWN_CPU;
    if (cpu_req && dbg_req) begin
      w_win = (w_last_eff == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (!cpu_req) begin
      w_win = OWN_DBG;
    end
  end

  assign w_cpu_cap = w_sample && (w_win == OWN_CPU);
  assign w_dbg_cap = w_sample && (w_win == OWN_DBG);

  pa_tracker u_cpu_pa (
    .clk       (clk),
    .reset     (reset),
    .i_set_pa  (cpu_set_pa),
    .i_capture (w_cpu_cap),
    .o_pa      (cpu_pa),
    .o_eff_pa  (w_cpu_eff_pa)
  );

  pa_tracker u_dbg_pa (
    .clk       (clk),
    .reset     (reset),
    .i_set_pa  (dbg_set_pa),
    .i_capture (w_dbg_cap),
    .o_pa      (dbg_pa),
    .o_eff_pa  (w_dbg_eff_pa)
  );

  assign w_cap_addr  = (w_win == OWN_CPU) ? {w_cpu_eff_pa, cpu_lower} : {w_dbg_eff_pa, dbg_lower};
  assign w_cap_we    = (w_win == OWN_CPU) ? cpu_we : dbg_we;
  assign w_cap_wdata = (w_win == OWN_CPU) ? cpu_wdata : dbg_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DBG;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sample) begin
            r_owner <= w_win;
            r_addr  <= w_cap_addr;
            r_we    <= w_cap_we;
            r_wdata <= w_cap_wdata;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_we) begin
            if (r_owner == OWN_CPU) r_cpu_rdata <= rf_rdata;
            else                    r_dbg_rdata <= rf_rdata;
          end
          r_state <= RESP;
        end
        RESP: begin
          r_last_owner <= r_owner;
          if (w_sample) begin
            r_owner <= w_win;
            r_addr  <= w_cap_addr;
            r_we    <= w_cap_we;
            r_wdata <= w_cap_wdata;
            r_state <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Decoded from state so reset removes the write strobe without waiting for a clock.
  assign rf_we       = (r_state == ACCESS) && r_we;
  assign rf_addr     = r_addr;
  assign rf_wdata    = r_wdata;
  assign cpu_gnt     = (r_state == ACCESS) && (r_owner == OWN_CPU);
  assign dbg_gnt     = (r_state == ACCESS) && (r_owner == OWN_DBG);
  assign cpu_done    = (r_state == RESP) && (r_owner == OWN_CPU);
  assign dbg_done    = (r_state == RESP) && (r_owner == OWN_DBG);
  assign cpu_rdata   = r_cpu_rdata;
  assign dbg_rdata   = r_dbg_rdata;
  assign o_fsm_state = r_state;
endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural register file.
module tb_rf_port_arbiter;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_req = 1'b0, dbg_req = 1'b0;
  logic [2:0]        cpu_set_pa = '0, dbg_set_pa = '0;
  logic [1:0]        cpu_lower = '0, dbg_lower = '0;
  logic              cpu_we = 1'b0, dbg_we = 1'b0;
  logic [DATA_W-1:0] cpu_wdata = '0, dbg_wdata = '0;
  logic              cpu_gnt, cpu_done, dbg_gnt, dbg_done;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic [1:0]        cpu_pa, dbg_pa;
  logic [3:0]        rf_addr;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata, rf_rdata;
  logic [1:0]        fsm_state;

  logic [DATA_W-1:0] mem [16];
  logic [0:0]        exp_q [$];
  int                n_checks = 0;
  int                n_fail = 0;

  rf_port_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_set_pa(cpu_set_pa), .cpu_lower(cpu_lower), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_pa(cpu_pa),
    .dbg_req(dbg_req), .dbg_set_pa(dbg_set_pa), .dbg_lower(dbg_lower), .dbg_we(dbg_we),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .dbg_pa(dbg_pa),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .o_fsm_state(fsm_state)
  );

  // clock / register file model
  always #5 clk = ~clk;
  assign rf_rdata = mem[rf_addr];
  always @(posedge clk) if (rf_we) mem[rf_addr] <= rf_wdata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic [2:0] spa, input logic [1:0] lo,
                           input logic we, input logic [7:0] wd);
    cpu_req = req; cpu_set_pa = spa; cpu_lower = lo; cpu_we = we; cpu_wdata = wd;
  endtask

  task automatic dbg_drive(input logic req, input logic [2:0] spa, input logic [1:0] lo,
                           input logic we, input logic [7:0] wd);
    dbg_req = req; dbg_set_pa = spa; dbg_lower = lo; dbg_we = we; dbg_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    mem[9] = 8'h5A;
    mem[12] = 8'hD4;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_dbg_done", dbg_done, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_pa", {cpu_pa, dbg_pa}, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;
    step();

    // cpu read, new play area 2
    cpu_drive(1, 3'b110, 2'b01, 0, 8'h00);
    step();
    check("rd_gnt", cpu_gnt, 1);
    check("rd_addr", rf_addr, 4'h9);
    check("rd_we", rf_we, 0);
    check("rd_cpu_pa", cpu_pa, 2'b10);
    cpu_req = 0;
    step();
    check("rd_done", cpu_done, 1);
    check("rd_rdata", cpu_rdata, 8'h5A);
    check("rd_gnt_off", cpu_gnt, 0);
    step();
    check("rd_done_off", cpu_done, 0);

    // cpu write reusing stored play area
    cpu_drive(1, 3'b001, 2'b11, 1, 8'hC3);
    step();
    check("wr_addr", rf_addr, 4'hB);
    check("wr_we", rf_we, 1);
    check("wr_wdata", rf_wdata, 8'hC3);
    cpu_req = 0;
    step();
    check("wr_we_off", rf_we, 0);
    check("wr_done", cpu_done, 1);
    check("wr_rdata_kept", cpu_rdata, 8'h5A);
    check("wr_mem", mem[11], 8'hC3);
    check("wr_pa_kept", cpu_pa, 2'b10);
    step();

    // dbg selects bank 3 while cpu keeps bank 2
    dbg_drive(1, 3'b111, 2'b00, 0, 8'h00);
    step();
    check("dbg_gnt", dbg_gnt, 1);
    check("dbg_addr", rf_addr, 4'hC);
    check("dbg_pa", dbg_pa, 2'b11);
    check("dbg_cpu_pa", cpu_pa, 2'b10);
    dbg_req = 0;
    step();
    check("dbg_done", dbg_done, 1);
    check("dbg_rdata", dbg_rdata, 8'hD4);
    check("dbg_cpu_rdata", cpu_rdata, 8'h5A);
    step();

    // reset during a write access
    cpu_drive(1, 3'b101, 2'b10, 1, 8'h77);
    step();
    check("rw_we_before", rf_we, 1);
    cpu_req = 0;
    reset = 1'b1;
    #1;
    check("rw_we_async", rf_we, 0);
    check("rw_pa", {cpu_pa, dbg_pa}, 0);
    @(posedge clk);
    #1;
    check("rw_no_done", {cpu_done, dbg_done}, 0);
    check("rw_mem", mem[6], 8'h16);
    reset = 1'b0;
    step();
    cpu_drive(1, 3'b000, 2'b01, 0, 8'h00);
    step();
    check("rw_next_addr", rf_addr, 4'h1);
    cpu_req = 0;
    step();
    check("rw_next_done", cpu_done, 1);
    check("rw_next_rdata", cpu_rdata, 8'h11);
    step();

    // continuous tie from reset: cpu, dbg, cpu, dbg
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    cpu_drive(1, 3'b000, 2'b00, 0, 8'h00);
    dbg_drive(1, 3'b000, 2'b01, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i % 2 == 0) begin
        check($sformatf("tie_gnt%0d", i), {cpu_gnt, dbg_gnt}, ((i / 2) % 2 == 0) ? 2'b10 : 2'b01);
        check($sformatf("tie_nodone%0d", i), {cpu_done, dbg_done}, 0);
      end else begin
        check($sformatf("tie_onedone%0d", i), 32'(cpu_done) + 32'(dbg_done), 1);
        if (exp_q.size() > 0) check($sformatf("tie_owner%0d", i), dbg_done, exp_q.pop_front());
        else check("tie_q_empty", 1, 0);
      end
      if (i == 6) begin
        cpu_req = 0;
        dbg_req = 0;
      end
    end
    check("tie_q_drained", exp_q.size(), 0);
    step();
    check("tie_idle", fsm_state, 0);

    // tie where the loser asks for a new bank
    cpu_drive(1, 3'b000, 2'b00, 0, 8'h00);
    dbg_drive(1, 3'b101, 2'b10, 0, 8'h00);
    step();
    check("lose_cpu_gnt", cpu_gnt, 1);
    check("lose_dbg_pa0", dbg_pa, 2'b00);
    cpu_req = 0;
    step();
    check("lose_dbg_pa1", dbg_pa, 2'b00);
    step();
    check("lose_dbg_gnt", dbg_gnt, 1);
    check("lose_dbg_pa2", dbg_pa, 2'b01);
    check("lose_addr", rf_addr, 4'h6);
    dbg_req = 0;
    step();
    check("lose_done", dbg_done, 1);
    check("lose_rdata", dbg_rdata, 8'h16);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
